// File: rtl/conv_mac_engine.sv
// Convolution MAC: one TAPS-pixel window through a runtime-programmed kernel,
// bias preload, round-half-up, ReLU and saturation to DATA_BITS fixed point.

module conv_mac_kbank #(
  parameter int DATA_BITS = 20,
  parameter int TAPS      = 9,
  parameter int TIDX_BITS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            we_i,
  input  logic [TIDX_BITS-1:0]            tidx_i,
  input  logic [DATA_BITS-1:0]            data_i,
  output logic [TAPS:0][DATA_BITS-1:0]    regs_o
);
  // Entries 0..TAPS-1 are weights, entry TAPS is the bias.
  logic [TAPS:0][DATA_BITS-1:0] regs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     regs_q <= '0;
    else if (we_i) regs_q[tidx_i] <= data_i;
  end

  assign regs_o = regs_q;
endmodule

module conv_mac_engine #(
  parameter int DATA_BITS  = 20,
  parameter int FRAC_BITS  = 16,
  parameter int TAPS       = 9,
  parameter int KERNEL_NUM = 2,
  parameter int KIDX_BITS  = 1,
  parameter int TIDX_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [KIDX_BITS-1:0] cfg_kidx,
  input  logic [TIDX_BITS-1:0] cfg_tidx,
  input  logic [DATA_BITS-1:0] cfg_data,
  input  logic                 start,
  input  logic [KIDX_BITS-1:0] ker_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_pixel,
  output logic [KIDX_BITS-1:0] out_kernel,
  output logic                 busy
);
  localparam int PW    = 2*DATA_BITS;
  localparam int ACC_W = 2*DATA_BITS + $clog2(TAPS+1);

  localparam logic [KIDX_BITS:0]   KNUM     = (KIDX_BITS+1)'(KERNEL_NUM);
  localparam logic [TIDX_BITS-1:0] BIAS_IDX = TIDX_BITS'(TAPS);
  localparam logic [TIDX_BITS-1:0] LAST_IDX = TIDX_BITS'(TAPS-1);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS-1);
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((64'sd1 <<< (DATA_BITS-1)) - 64'sd1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_ROUND, S_OUT} state_e;

  state_e                      state_q, state_d;
  logic [TIDX_BITS-1:0]        tap_q, tap_d;
  logic [KIDX_BITS-1:0]        kern_q, kern_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [PW-1:0]        prod_q, prod_d;
  logic                        pvld_q, pvld_d;
  logic [DATA_BITS-1:0]        opix_q, opix_d;
  logic                        ovld_q, ovld_d;
  logic [KIDX_BITS-1:0]        okern_q, okern_d;

  // Weight/bias file: one bank per kernel
  logic [TAPS:0][DATA_BITS-1:0] wbank [KERNEL_NUM];
  logic [KERNEL_NUM-1:0]        bank_we;
  logic                         cfg_ok;

  assign cfg_ok = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_kidx} < KNUM) &&
                  (cfg_tidx <= BIAS_IDX);

  for (genvar g = 0; g < KERNEL_NUM; g++) begin : g_bank
    assign bank_we[g] = cfg_ok && (cfg_kidx == KIDX_BITS'(g));
    conv_mac_kbank #(
      .DATA_BITS (DATA_BITS),
      .TAPS      (TAPS),
      .TIDX_BITS (TIDX_BITS)
    ) u_kbank (
      .clk    (clk),
      .reset  (reset),
      .we_i   (bank_we[g]),
      .tidx_i (cfg_tidx),
      .data_i (cfg_data),
      .regs_o (wbank[g])
    );
  end

  logic                        start_ok;
  logic signed [DATA_BITS-1:0] pix_s, w_sel, bias_sel;
  logic signed [ACC_W-1:0]     acc_rnd, rnd_q;

  assign start_ok = start && (state_q == S_IDLE) && ({1'b0, ker_sel} < KNUM);
  assign pix_s    = in_pixel;
  assign w_sel    = wbank[kern_q][tap_q];
  assign bias_sel = wbank[ker_sel][BIAS_IDX];
  assign acc_rnd  = acc_q + RND_HALF;
  assign rnd_q    = acc_rnd >>> FRAC_BITS;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    kern_d  = kern_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    pvld_d  = 1'b0;
    opix_d  = opix_q;
    ovld_d  = ovld_q;
    okern_d = okern_q;
    // Product registered on an accept lands in the accumulator one edge later
    if (pvld_q) acc_d = acc_q + ACC_W'(prod_q);
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          kern_d  = ker_sel;
          tap_d   = '0;
          acc_d   = ACC_W'(bias_sel) <<< FRAC_BITS;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          prod_d = PW'(pix_s) * PW'(w_sel);
          pvld_d = 1'b1;
          tap_d  = tap_q + 1'b1;
          if (tap_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_ROUND;
      S_ROUND: begin
        ovld_d  = 1'b1;
        okern_d = kern_q;
        if (rnd_q[ACC_W-1])      opix_d = '0;
        else if (rnd_q > OUT_MAX) opix_d = OUT_MAX[DATA_BITS-1:0];
        else                      opix_d = rnd_q[DATA_BITS-1:0];
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      kern_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      pvld_q  <= 1'b0;
      opix_q  <= '0;
      ovld_q  <= 1'b0;
      okern_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      kern_q  <= kern_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      pvld_q  <= pvld_d;
      opix_q  <= opix_d;
      ovld_q  <= ovld_d;
      okern_q <= okern_d;
    end
  end

  assign in_ready   = (state_q == S_ACCUM);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = ovld_q;
  assign out_pixel  = opix_q;
  assign out_kernel = okern_q;
endmodule
